// File: rtl/score_pkg.sv
// Shared types and helpers for the score controller: game phase encoding and BCD utilities.
// Pure declarations; no state, no latency.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef logic [4*BCD_W-1:0] bcd4_t;

    // Digit-wise compare from the most significant digit down; first differing digit decides.
    function automatic logic bcd_gt(input bcd4_t a, input bcd4_t b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!done && (a[i*BCD_W +: BCD_W] != b[i*BCD_W +: BCD_W])) begin
                gt   = (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]);
                done = 1'b1;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/score_ctrl_collision_cond.sv
// Turns a raw collision level into a single accept pulse per rising edge, then ignores edges for HOLDOFF_CYCLES.
// accept is combinational in the edge cycle; no backpressure.
module collision_cond #(
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic collision,
    output logic accept
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic [HW-1:0] holdoff;
    logic          coll_q;

    assign accept = enable && collision && !coll_q && (holdoff == '0);

    // History and hold-off run in every phase so an edge is always relative to the previous cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            holdoff <= '0;
            coll_q  <= 1'b0;
        end else begin
            coll_q <= collision;
            if (accept) begin
                holdoff <= HW'(HOLDOFF_CYCLES);
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HW'(1);
            end
        end
    end

endmodule

// File: rtl/score_ctrl.sv
// Game-phase FSM driving the BCD score counter, tracking the best score and choosing the displayed value.
// score_inc/score_clr are registered one cycle after their cause; no backpressure.
module score_ctrl
    import score_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 16,
    parameter int DISP_CYCLES    = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             game_over,
    input  logic             collision,
    input  logic [BCD_W-1:0] thous,
    input  logic [BCD_W-1:0] huns,
    input  logic [BCD_W-1:0] tens,
    input  logic [BCD_W-1:0] ones,
    output logic             score_inc,
    output logic             score_clr,
    output logic [BCD_W-1:0] best_thous,
    output logic [BCD_W-1:0] best_huns,
    output logic [BCD_W-1:0] best_tens,
    output logic [BCD_W-1:0] best_ones,
    output logic             new_best,
    output logic             disp_sel,
    output logic [BCD_W-1:0] disp_thous,
    output logic [BCD_W-1:0] disp_huns,
    output logic [BCD_W-1:0] disp_tens,
    output logic [BCD_W-1:0] disp_ones,
    output logic [1:0]       state
);

    localparam int TW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    state_t        cur, nxt;
    bcd4_t         best_q, best_nx, cur_score, disp_score;
    logic [TW-1:0] timer, timer_nx;
    logic          inc_nx, clr_nx, nb_nx, dsel_nx;
    logic          cmp_pend, pend_nx;
    logic          accept, saturated, coll_en;

    assign cur_score = {thous, huns, tens, ones};
    assign saturated = (thous == BCD_MAX) && (huns == BCD_MAX) &&
                       (tens == BCD_MAX) && (ones == BCD_MAX);

    // game_over in the same cycle discards the edge entirely, hold-off included.
    assign coll_en = (cur == PLAY) && !game_over;

    collision_cond #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_cond (
        .clk      (clk),
        .reset    (reset),
        .enable   (coll_en),
        .collision(collision),
        .accept   (accept)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur       <= IDLE;
            score_inc <= 1'b0;
            score_clr <= 1'b0;
            best_q    <= '0;
            new_best  <= 1'b0;
            disp_sel  <= 1'b0;
            timer     <= '0;
            cmp_pend  <= 1'b0;
        end else begin
            cur       <= nxt;
            score_inc <= inc_nx;
            score_clr <= clr_nx;
            best_q    <= best_nx;
            new_best  <= nb_nx;
            disp_sel  <= dsel_nx;
            timer     <= timer_nx;
            cmp_pend  <= pend_nx;
        end
    end

    always_comb begin
        nxt      = cur;
        inc_nx   = 1'b0;
        clr_nx   = 1'b0;
        best_nx  = best_q;
        nb_nx    = new_best;
        dsel_nx  = disp_sel;
        timer_nx = timer;
        pend_nx  = cmp_pend;

        // Deferred one edge into OVER so a final increment has reached the counter.
        if ((cur == OVER) && cmp_pend) begin
            pend_nx = 1'b0;
            if (bcd_gt(cur_score, best_q)) begin
                best_nx = cur_score;
                nb_nx   = 1'b1;
            end else begin
                nb_nx   = 1'b0;
            end
        end

        case (cur)
            IDLE: begin
                if (start) begin
                    nxt    = PLAY;
                    clr_nx = 1'b1;
                end
            end
            PLAY: begin
                inc_nx = accept && !saturated;
                if (game_over) begin
                    nxt      = OVER;
                    pend_nx  = 1'b1;
                    timer_nx = '0;
                    dsel_nx  = 1'b0;
                end
            end
            OVER: begin
                if (start) begin
                    nxt      = PLAY;
                    clr_nx   = 1'b1;
                    nb_nx    = 1'b0;
                    dsel_nx  = 1'b0;
                    timer_nx = '0;
                end else if (timer == TW'(DISP_CYCLES - 1)) begin
                    timer_nx = '0;
                    dsel_nx  = !disp_sel;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign disp_score = disp_sel ? best_q : cur_score;

    assign best_thous = best_q[15:12];
    assign best_huns  = best_q[11:8];
    assign best_tens  = best_q[7:4];
    assign best_ones  = best_q[3:0];

    assign disp_thous = disp_score[15:12];
    assign disp_huns  = disp_score[11:8];
    assign disp_tens  = disp_score[7:4];
    assign disp_ones  = disp_score[3:0];

    assign state = cur;

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench for score_ctrl: directed table, hand-written corner sequences, random run vs a reference model.
module tb_score_ctrl;

    localparam int HOLD = 16;
    localparam int DISP = 4;

    logic       clk;
    logic       reset, start, game_over, collision;
    logic [3:0] thous, huns, tens, ones;
    logic       score_inc, score_clr, new_best, disp_sel;
    logic [3:0] best_thous, best_huns, best_tens, best_ones;
    logic [3:0] disp_thous, disp_huns, disp_tens, disp_ones;
    logic [1:0] state;

    int score;
    bit cnt_mode;
    int vectors, miscompares;

    assign thous = 4'(score / 1000);
    assign huns  = 4'((score / 100) % 10);
    assign tens  = 4'((score / 10) % 10);
    assign ones  = 4'(score % 10);

    score_ctrl #(.HOLDOFF_CYCLES(HOLD), .DISP_CYCLES(DISP)) dut (
        .clk(clk), .reset(reset), .start(start), .game_over(game_over), .collision(collision),
        .thous(thous), .huns(huns), .tens(tens), .ones(ones),
        .score_inc(score_inc), .score_clr(score_clr),
        .best_thous(best_thous), .best_huns(best_huns), .best_tens(best_tens), .best_ones(best_ones),
        .new_best(new_best), .disp_sel(disp_sel),
        .disp_thous(disp_thous), .disp_huns(disp_huns), .disp_tens(disp_tens), .disp_ones(disp_ones),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase as 0/1/2, scores as plain integers, hold-off as cycles remaining.
    int m_state, m_hold, m_best, m_timer;
    bit m_prev, m_inc, m_clr, m_nb, m_dsel, m_pend;

    function automatic int dut_best();
        return int'(best_thous) * 1000 + int'(best_huns) * 100 + int'(best_tens) * 10 + int'(best_ones);
    endfunction

    function automatic int dut_disp();
        return int'(disp_thous) * 1000 + int'(disp_huns) * 100 + int'(disp_tens) * 10 + int'(disp_ones);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step_model();
        bit edge_seen, acc;
        if (!reset) begin
            m_state = 0; m_hold = 0; m_best = 0; m_timer = 0;
            m_prev = 0; m_inc = 0; m_clr = 0; m_nb = 0; m_dsel = 0; m_pend = 0;
            return;
        end
        edge_seen = collision && !m_prev;
        m_prev    = collision;
        acc       = (m_state == 1) && !game_over && edge_seen && (m_hold == 0);
        if (acc) m_hold = HOLD;
        else if (m_hold > 0) m_hold--;
        m_inc = acc && (score != 9999);
        m_clr = 0;
        if (m_state == 2 && m_pend) begin
            m_pend = 0;
            if (score > m_best) begin m_best = score; m_nb = 1; end
            else m_nb = 0;
        end
        case (m_state)
            0: if (start) begin m_state = 1; m_clr = 1; end
            1: if (game_over) begin m_state = 2; m_pend = 1; m_timer = 0; m_dsel = 0; end
            default: begin
                if (start) begin
                    m_state = 1; m_clr = 1; m_nb = 0; m_dsel = 0; m_timer = 0;
                end else if (m_timer == DISP - 1) begin
                    m_timer = 0; m_dsel = !m_dsel;
                end else begin
                    m_timer++;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("state", int'(state), m_state);
        chk("score_inc", int'(score_inc), int'(m_inc));
        chk("score_clr", int'(score_clr), int'(m_clr));
        chk("best", dut_best(), m_best);
        chk("new_best", int'(new_best), int'(m_nb));
        chk("disp_sel", int'(disp_sel), int'(m_dsel));
        chk("disp", dut_disp(), m_dsel ? m_best : score);
    endtask

    // One clock: model steps on the pre-edge inputs, external counter follows the pulses seen before the edge.
    task automatic tick();
        bit oc, oi;
        oc = m_clr;
        oi = m_inc;
        step_model();
        @(posedge clk);
        #1;
        if (cnt_mode) begin
            if (oc) score = 0;
            else if (oi && score < 9999) score++;
        end
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        start = 0; game_over = 0; collision = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        bit rst, st, go, col;
        int sc;
        int e_state;
        bit e_inc, e_clr;
        int e_best;
        bit e_nb, e_dsel;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(bit rst, bit st, bit go, bit col, int sc,
                                int es, bit ei, bit ec, int eb, bit en, bit ed);
        vec_t v;
        v.rst = rst; v.st = st; v.go = go; v.col = col; v.sc = sc;
        v.e_state = es; v.e_inc = ei; v.e_clr = ec; v.e_best = eb; v.e_nb = en; v.e_dsel = ed;
        return v;
    endfunction

    int incs;
    bit dsel_exp[9];

    initial begin
        vectors = 0; miscompares = 0;
        reset = 0; start = 0; game_over = 0; collision = 0;
        score = 0; cnt_mode = 0;
        #2;

        //            rst st go col sc   state inc clr best nb dsel
        tbl[0]  = mk(0, 0, 0, 0,  0,   0, 0, 0,  0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1,  0,   0, 0, 0,  0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0,  0,   1, 0, 1,  0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0,  0,   1, 0, 0,  0, 0, 0);
        tbl[4]  = mk(1, 0, 0, 1, 41,   1, 1, 0,  0, 0, 0);
        tbl[5]  = mk(1, 0, 0, 1, 41,   1, 0, 0,  0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, 42,   1, 0, 0,  0, 0, 0);
        tbl[7]  = mk(1, 0, 1, 0, 42,   2, 0, 0,  0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 42,   2, 0, 0, 42, 1, 0);
        tbl[9]  = mk(1, 1, 0, 0, 42,   1, 0, 1, 42, 0, 0);
        tbl[10] = mk(1, 0, 1, 1, 42,   2, 0, 0, 42, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 42,   2, 0, 0, 42, 0, 0);
        tbl[12] = mk(1, 1, 0, 0, 42,   1, 0, 1, 42, 0, 0);

        for (int i = 0; i < 13; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; game_over = tbl[i].go;
            collision = tbl[i].col; score = tbl[i].sc;
            tick();
            chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].e_state);
            chk($sformatf("tbl%0d_inc", i), int'(score_inc), int'(tbl[i].e_inc));
            chk($sformatf("tbl%0d_clr", i), int'(score_clr), int'(tbl[i].e_clr));
            chk($sformatf("tbl%0d_best", i), dut_best(), tbl[i].e_best);
            chk($sformatf("tbl%0d_nb", i), int'(new_best), int'(tbl[i].e_nb));
            chk($sformatf("tbl%0d_dsel", i), int'(disp_sel), int'(tbl[i].e_dsel));
        end

        // Held collision gives one increment.
        reset = 0; idle(1); reset = 1;
        start = 1; tick(); start = 0;
        chk("t1_clr", int'(score_clr), 1);
        chk("t1_play", int'(state), 1);
        incs = 0; collision = 1;
        for (int i = 0; i < 40; i++) begin tick(); incs += int'(score_inc); end
        collision = 0; tick(); incs += int'(score_inc);
        chk("t1_one_inc", incs, 1);

        // Hold-off: edges at t=0,10,20 yield two pulses.
        idle(20);
        incs = 0;
        for (int t = 0; t < 32; t++) begin
            collision = (t == 0 || t == 10 || t == 20);
            tick(); incs += int'(score_inc);
        end
        chk("t2_holdoff", incs, 2);

        // Saturation at 9999, not at 9998.
        idle(20);
        score = 9999; incs = 0;
        collision = 1; tick(); incs += int'(score_inc);
        collision = 0; tick(); incs += int'(score_inc);
        chk("t3_sat", incs, 0);
        idle(20);
        score = 9998; incs = 0;
        collision = 1; tick(); incs += int'(score_inc);
        collision = 0; tick(); incs += int'(score_inc);
        chk("t3_9998", incs, 1);

        // Best score across three games.
        reset = 0; idle(1); reset = 1;
        start = 1; tick(); start = 0;
        score = 42; game_over = 1; tick(); game_over = 0; tick();
        chk("t4_g1_best", dut_best(), 42);
        chk("t4_g1_nb", int'(new_best), 1);
        start = 1; tick(); start = 0;
        game_over = 1; tick(); game_over = 0; tick();
        chk("t4_g2_best", dut_best(), 42);
        chk("t4_g2_nb", int'(new_best), 0);
        start = 1; tick(); start = 0;
        score = 105; game_over = 1; tick(); game_over = 0; tick();
        chk("t4_g3_best", dut_best(), 105);
        chk("t4_g3_nb", int'(new_best), 1);

        // Display alternation in OVER.
        dsel_exp = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        start = 1; tick(); start = 0;
        score = 77; game_over = 1; tick(); game_over = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            chk($sformatf("t5_dsel%0d", i), int'(disp_sel), int'(dsel_exp[i]));
            if (i == 0) chk("t5_disp_cur", dut_disp(), 77);
            if (i == 4) chk("t5_disp_best", dut_disp(), 105);
        end
        start = 1; tick(); start = 0;
        chk("t5_start_dsel", int'(disp_sel), 0);

        // game_over beats a simultaneous collision edge; reset mid-PLAY.
        idle(20);
        game_over = 1; collision = 1; tick();
        chk("t6_go_inc", int'(score_inc), 0);
        chk("t6_go_state", int'(state), 2);
        game_over = 0; collision = 0;
        start = 1; tick(); start = 0;
        idle(20);
        collision = 1; reset = 0; tick();
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_inc", int'(score_inc), 0);
        chk("t6_rst_best", dut_best(), 0);
        chk("t6_rst_nb", int'(new_best), 0);
        reset = 1; collision = 0; idle(2);

        // Random run with the bench acting as the score counter.
        cnt_mode = 1; score = 0;
        for (int i = 0; i < 3000; i++) begin
            reset     = !($urandom_range(0, 499) == 0);
            start     = ($urandom_range(0, 39) == 0);
            game_over = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) collision = !collision;
            if ($urandom_range(0, 299) == 0) score = $urandom_range(9990, 9999);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_ctrl.md
Name: score_ctrl

Overview:
- Sequences the 4-digit BCD score counter for the game.
- Conditions the raw multi-cycle collision level into single-cycle increment pulses, with edge detect and hold-off.
- Runs the game-phase FSM (IDLE/PLAY/OVER) and keeps a best-score register across games.
- Selects which value (current or best) the seven-segment driver shows.

Parameters:
- HOLDOFF_CYCLES, 16: cycles after an accepted collision during which further collision edges are ignored. Must be ≥1.
- DISP_CYCLES, 50_000_000: cycles per current/best alternation in OVER (1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  single-cycle start/restart pulse (already debounced)
- game_over  in  1  single-cycle end-of-game pulse from game logic
- collision  in  1  raw collision level, may stay high many cycles
- thous, huns, tens, ones  in  4 each  current score digits from the counter
- score_inc  out  1  one-cycle increment pulse to the counter
- score_clr  out  1  one-cycle clear pulse to the counter
- best_thous, best_huns, best_tens, best_ones  out  4 each  best score
- new_best  out  1  high in OVER when the last game beat the best score
- disp_sel  out  1  0 = current score shown, 1 = best shown
- disp_thous, disp_huns, disp_tens, disp_ones  out  4 each  digits to display
- state  out  2  IDLE=0, PLAY=1, OVER=2

Behaviour:
- Reset (reset=0 at a clk edge) sets:
  - state=IDLE; score_inc=0; score_clr=0; best digits=0; new_best=0; disp_sel=0.
  - holdoff counter=0; collision history register=0; display timer=0.
- IDLE:
  - On start=1: go to PLAY and pulse score_clr for one cycle, registered in the same edge.
  - Collisions are ignored.
- PLAY:
  - A rising edge means collision=1 now and 0 in the previous cycle.
  - An edge is accepted when the holdoff counter is 0. On acceptance, the next cycle has score_inc=1 for exactly one cycle, and the holdoff counter loads HOLDOFF_CYCLES and decrements each cycle to 0.
  - If the input digits are 9,9,9,9, an accepted edge produces no pulse. This saturates the score with no wrap.
  - game_over=1 goes to OVER. A collision edge in the same cycle is discarded, so game_over takes priority.
  - start=1 in PLAY is ignored.
- OVER:
  - No score_inc is issued.
  - On the first edge in OVER, compare current vs best as 16-bit BCD (thous most significant).
    - If strictly greater: best ← current and new_best ← 1.
    - Otherwise: new_best ← 0.
  - This compare happens exactly once per OVER entry. Any score_inc issued before the transition has already landed in the counter.
  - disp_sel toggles every DISP_CYCLES cycles, starting at 0 on OVER entry.
  - start=1 goes to PLAY with a score_clr pulse. new_best and disp_sel clear, and the timer resets.
- disp digits:
  - Combinational mux: current digits when disp_sel=0, best digits when disp_sel=1.
  - disp_sel=0 in IDLE and PLAY.
- Simultaneous events:
  - start and game_over in PLAY: game_over wins.
  - start and game_over in OVER: start wins.
  - game_over in IDLE or OVER: ignored.
- Best score persists across games and is cleared only by reset.
- Reset asserted mid-PLAY: any pending score_inc is dropped; outputs go to reset values on that edge.
- Holdoff counter width is clog2(HOLDOFF_CYCLES+1). Display timer width is clog2(DISP_CYCLES).

Decomposition:
- Package score_pkg holds:
  - the state enum (IDLE, PLAY, OVER) with 2-bit encoding;
  - the BCD digit width constant (4);
  - the BCD max-digit constant (9);
  - a function for BCD greater-than over four digits.
- Sub-module collision_cond (edge detect plus hold-off, parameter HOLDOFF_CYCLES):
  - inputs: clk, reset, enable, collision;
  - output: accept, a one-cycle pulse.
- The FSM, best register, saturation check and display logic stay in score_ctrl.

Test Plan:
1. Reset, start pulse → score_clr=1 for one cycle, state=PLAY. Collision held high 40 cycles → exactly one score_inc.
2. HOLDOFF_CYCLES=16: edges at t=0, t=10 and t=20 → pulses for t=0 and t=20 only.
3. Score input 9999, collision edge → no score_inc. Score input 9998 → one pulse.
4. Game 1 ends at score 0042, best 0000 → best=0042, new_best=1. Game 2 ends at 0042 → best=0042, new_best=0. Game 3 ends at 0105 → best=0105, new_best=1.
5. DISP_CYCLES=4 in OVER → disp_sel sequence 0,0,0,0,1,1,1,1,0. disp digits follow the current/best mux. start → disp_sel=0.
6. game_over and a collision edge in the same cycle → no score_inc, state=OVER. reset=0 mid-PLAY → all outputs back to reset values and best cleared.
